// File: rtl/mor1kx_tlb_reload_walker.sv
// Memory-side responder for the hardware TLB reload interface.
//
// The instruction and data MMUs each present a level request plus a read
// address. This block arbitrates between them, performs one Wishbone classic
// read per accepted request and returns the word with a one-cycle ack. Walk
// state lives in the MMUs; the only walk-related state kept here is a lock
// that keeps a pointer-then-PTE pair atomic for the owning MMU.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   itlb_reload_req_i/addr_i  IMMU request (level, held until ack) and address
//   itlb_reload_ack_o/data_o  one-cycle ack to the IMMU, data valid with ack
//   dtlb_reload_req_i/addr_i  DMMU request and address
//   dtlb_reload_ack_o/data_o  one-cycle ack to the DMMU, data valid with ack
//   wbm_*                     Wishbone classic read master (word aligned)
//   busy_o                    high whenever the walker is not idle
//   bus_err_o                 one-cycle pulse on err or timeout termination
module mor1kx_tlb_reload_walker #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_TIMEOUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            itlb_reload_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] itlb_reload_addr_i,
  output logic                            itlb_reload_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] itlb_reload_data_o,
  input  logic                            dtlb_reload_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dtlb_reload_addr_i,
  output logic                            dtlb_reload_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dtlb_reload_data_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [3:0]                      wbm_sel_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  output logic                            busy_o,
  output logic                            bus_err_o
);

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  localparam logic [OPTION_OPERAND_WIDTH-1:0] ADR_MASK =
    {{(OPTION_OPERAND_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [OPTION_TIMEOUT_WIDTH-1:0] TIMER_ONE =
    {{(OPTION_TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                            state;
  logic                              locked;
  logic                              owner;
  logic                              last_grant;
  logic [OPTION_TIMEOUT_WIDTH-1:0]   timer;
  logic [OPTION_OPERAND_WIDTH-1:0]   data_q;
  logic                              cyc_q;

  logic                              owner_req;
  logic                              grant_any;
  logic                              grant_src;
  logic [OPTION_OPERAND_WIDTH-1:0]   grant_addr;
  logic                              timeout;
  logic                              term;

  assign owner_req  = (owner == SRC_D) ? dtlb_reload_req_i : itlb_reload_req_i;
  assign grant_any  = itlb_reload_req_i | dtlb_reload_req_i;
  assign grant_addr = (grant_src == SRC_D) ? dtlb_reload_addr_i : itlb_reload_addr_i;

  // A locked owner keeps the bus for the second read of its walk; otherwise a
  // lone requester wins and a tie goes to whoever was not served last.
  always_comb begin
    grant_src = SRC_I;
    if (locked && owner_req) begin
      grant_src = owner;
    end else if (itlb_reload_req_i && dtlb_reload_req_i) begin
      grant_src = ~last_grant;
    end else if (dtlb_reload_req_i) begin
      grant_src = SRC_D;
    end
  end

  // The timer only counts while in BUS, so saturation is the timeout.
  assign timeout = &timer;
  assign term    = wbm_ack_i | wbm_err_i | timeout;

  assign itlb_reload_data_o = data_q;
  assign dtlb_reload_data_o = data_q;
  assign wbm_cyc_o          = cyc_q;
  assign wbm_stb_o          = cyc_q;
  assign wbm_we_o           = 1'b0;
  assign wbm_sel_o          = 4'hf;
  assign busy_o             = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      locked            <= 1'b0;
      owner             <= SRC_I;
      last_grant        <= SRC_D;
      timer             <= '0;
      data_q            <= '0;
      cyc_q             <= 1'b0;
      wbm_adr_o         <= '0;
      itlb_reload_ack_o <= 1'b0;
      dtlb_reload_ack_o <= 1'b0;
      bus_err_o         <= 1'b0;
    end else begin
      itlb_reload_ack_o <= 1'b0;
      dtlb_reload_ack_o <= 1'b0;
      bus_err_o         <= 1'b0;
      case (state)
        IDLE: begin
          // The lock only needs to survive the single IDLE cycle after RESP;
          // RESP re-arms it after every completed read.
          locked <= 1'b0;
          if (grant_any) begin
            owner     <= grant_src;
            wbm_adr_o <= grant_addr & ADR_MASK;
            cyc_q     <= 1'b1;
            timer     <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (term) begin
            cyc_q     <= 1'b0;
            bus_err_o <= ~wbm_ack_i;
            if (owner_req) begin
              // A zero word makes the MMU raise a pagefault on err/timeout.
              data_q            <= wbm_ack_i ? wbm_dat_i : '0;
              itlb_reload_ack_o <= (owner == SRC_I);
              dtlb_reload_ack_o <= (owner == SRC_D);
              state             <= RESP;
            end else begin
              locked <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        RESP: begin
          locked     <= 1'b1;
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_tlb_reload_walker.sv
module tb_mor1kx_tlb_reload_walker;

  localparam int W  = 32;
  localparam int TW = 8;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_BOTH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ireq = 1'b0;
  logic [W-1:0]  iaddr = '0;
  logic          iack;
  logic [W-1:0]  idata;
  logic          dreq = 1'b0;
  logic [W-1:0]  daddr = '0;
  logic          dack;
  logic [W-1:0]  ddata;
  logic [W-1:0]  wbm_adr_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [W-1:0]  wbm_dat_i = '0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;
  logic          busy_o;
  logic          bus_err_o;

  int checks = 0;
  int errors = 0;

  int           slv_wait = 0;
  int           slv_mode = M_ACK;
  logic [W-1:0] slv_data = '0;
  int           wcnt = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_walker #(
    .OPTION_OPERAND_WIDTH(W),
    .OPTION_TIMEOUT_WIDTH(TW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .itlb_reload_req_i  (ireq),
    .itlb_reload_addr_i (iaddr),
    .itlb_reload_ack_o  (iack),
    .itlb_reload_data_o (idata),
    .dtlb_reload_req_i  (dreq),
    .dtlb_reload_addr_i (daddr),
    .dtlb_reload_ack_o  (dack),
    .dtlb_reload_data_o (ddata),
    .wbm_adr_o          (wbm_adr_o),
    .wbm_cyc_o          (wbm_cyc_o),
    .wbm_stb_o          (wbm_stb_o),
    .wbm_we_o           (wbm_we_o),
    .wbm_sel_o          (wbm_sel_o),
    .wbm_dat_i          (wbm_dat_i),
    .wbm_ack_i          (wbm_ack_i),
    .wbm_err_i          (wbm_err_i),
    .busy_o             (busy_o),
    .bus_err_o          (bus_err_o)
  );

  // Wishbone slave: terminates after slv_wait wait states in the chosen mode.
  always @(negedge clk) begin
    if (wbm_stb_o) begin
      if (wcnt >= slv_wait) begin
        wbm_ack_i = (slv_mode == M_ACK) || (slv_mode == M_BOTH);
        wbm_err_i = (slv_mode == M_ERR) || (slv_mode == M_BOTH);
        wbm_dat_i = slv_data;
      end
      wcnt = wcnt + 1;
    end else begin
      wcnt      = 0;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = 32'h5A5A_0F0F;
    end
  end

  // Reference rules: the returned word is the slave data only on ack.
  function automatic logic [W-1:0] model_word(input int mode, input logic [W-1:0] d);
    return (mode == M_ERR || mode == M_NONE) ? '0 : d;
  endfunction

  // Reference latency: stb one cycle after req, ack_o one cycle after the
  // bus termination cycle.
  function automatic int model_ack_cycle(input int wait_states);
    return wait_states + 2;
  endfunction

  typedef struct {
    int           k_stb;
    int           k_ack;
    int           stb_n;
    int           berr_n;
    int           acks_i;
    int           acks_d;
    logic [W-1:0] adr;
    logic [W-1:0] data;
  } rd_t;

  // Observes negedges until an ack appears (or the limit expires).
  task automatic run_read(input int limit, output rd_t r);
    r.k_stb = -1; r.k_ack = -1; r.stb_n = 0; r.berr_n = 0;
    r.acks_i = 0; r.acks_d = 0; r.adr = '0; r.data = '0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (wbm_stb_o) begin
        r.stb_n++;
        if (r.k_stb < 0) begin r.k_stb = k; r.adr = wbm_adr_o; end
      end
      if (bus_err_o) r.berr_n++;
      if (iack) r.acks_i++;
      if (dack) r.acks_d++;
      if (iack || dack) begin
        r.k_ack = k;
        r.data  = iack ? idata : ddata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({iack, dack, wbm_cyc_o, wbm_stb_o, busy_o, bus_err_o} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {iack, dack, wbm_cyc_o, wbm_stb_o, busy_o, bus_err_o}); end
    checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", wbm_adr_o); end
    checks++; if (idata !== 32'h0) begin errors++; $display("FAIL reset_idata got %h exp 0", idata); end
    checks++; if (ddata !== 32'h0) begin errors++; $display("FAIL reset_ddata got %h exp 0", ddata); end
    checks++; if (wbm_sel_o !== 4'hf) begin errors++; $display("FAIL reset_sel got %h exp f", wbm_sel_o); end
    checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", wbm_we_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    rd_t r;
    slv_mode = M_ACK; slv_wait = 2; slv_data = 32'hCAFE_0400;
    iaddr = 32'h0000_1007; ireq = 1'b1;
    run_read(20, r);
    checks++; if (r.k_stb !== 1) begin errors++; $display("FAIL single_stb_cycle got %0d exp 1", r.k_stb); end
    checks++; if (r.adr !== 32'h0000_1004) begin errors++; $display("FAIL single_adr got %h exp 00001004", r.adr); end
    checks++; if (r.k_ack !== r.k_stb + 3) begin errors++; $display("FAIL single_ack_cycle got %0d exp %0d", r.k_ack, r.k_stb + 3); end
    checks++; if ({r.acks_i, r.acks_d} !== {32'd1, 32'd0}) begin errors++; $display("FAIL single_ack_target got i=%0d d=%0d exp i=1 d=0", r.acks_i, r.acks_d); end
    checks++; if (r.data !== 32'hCAFE_0400) begin errors++; $display("FAIL single_data got %h exp cafe0400", r.data); end
    checks++; if (ddata !== 32'hCAFE_0400) begin errors++; $display("FAIL single_shared_data got %h exp cafe0400", ddata); end
    checks++; if (r.berr_n !== 0) begin errors++; $display("FAIL single_berr got %0d exp 0", r.berr_n); end
    ireq = 1'b0;
    @(negedge clk);
    checks++; if ({iack, dack, busy_o} !== 3'b0) begin errors++; $display("FAIL single_after got %b exp 000", {iack, dack, busy_o}); end
  endtask

  task automatic test_walk();
    rd_t r;
    logic [W-1:0] a1, d2, d3, da;
    a1 = $urandom; d2 = $urandom | 32'h1; d3 = $urandom | 32'h1; da = $urandom;
    slv_mode = M_ACK; slv_wait = 0; slv_data = 32'h0040_0000;
    iaddr = a1; ireq = 1'b1;
    @(negedge clk);
    checks++; if ({wbm_stb_o, wbm_adr_o} !== {1'b1, a1 & 32'hFFFF_FFFC}) begin errors++; $display("FAIL walk_ptr_stb got %b %h exp 1 %h", wbm_stb_o, wbm_adr_o, a1 & 32'hFFFF_FFFC); end
    dreq = 1'b1; daddr = da;
    run_read(20, r);
    checks++; if ({r.k_ack, r.acks_i, r.acks_d} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL walk_ptr_ack got k=%0d i=%0d d=%0d exp k=1 i=1 d=0", r.k_ack, r.acks_i, r.acks_d); end
    checks++; if (r.data !== 32'h0040_0000) begin errors++; $display("FAIL walk_ptr_data got %h exp 00400000", r.data); end
    iaddr = 32'h0040_0010; slv_data = d2;
    run_read(20, r);
    checks++; if (r.k_stb !== 2) begin errors++; $display("FAIL walk_pte_stb_cycle got %0d exp 2", r.k_stb); end
    checks++; if (r.adr !== 32'h0040_0010) begin errors++; $display("FAIL walk_pte_adr got %h exp 00400010", r.adr); end
    checks++; if ({r.k_ack, r.acks_i, r.acks_d} !== {32'd3, 32'd1, 32'd0}) begin errors++; $display("FAIL walk_pte_ack got k=%0d i=%0d d=%0d exp k=3 i=1 d=0", r.k_ack, r.acks_i, r.acks_d); end
    checks++; if (r.data !== d2) begin errors++; $display("FAIL walk_pte_data got %h exp %h", r.data, d2); end
    ireq = 1'b0; slv_data = d3;
    run_read(20, r);
    checks++; if (r.adr !== (da & 32'hFFFF_FFFC)) begin errors++; $display("FAIL walk_dmmu_adr got %h exp %h", r.adr, da & 32'hFFFF_FFFC); end
    checks++; if ({r.k_stb, r.acks_i, r.acks_d} !== {32'd2, 32'd0, 32'd1}) begin errors++; $display("FAIL walk_dmmu_ack got stb=%0d i=%0d d=%0d exp stb=2 i=0 d=1", r.k_stb, r.acks_i, r.acks_d); end
    checks++; if (r.data !== d3) begin errors++; $display("FAIL walk_dmmu_data got %h exp %h", r.data, d3); end
    dreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    rd_t r;
    logic [W-1:0] exp_d;
    int got, exp_who;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    slv_mode = M_ACK; slv_wait = $urandom_range(0, 3); exp_d = $urandom; slv_data = exp_d;
    iaddr = $urandom; daddr = $urandom; ireq = 1'b1; dreq = 1'b1;
    for (int n = 0; n < 4; n++) begin
      run_read(40, r);
      exp_who = n % 2;
      got = (r.acks_d > 0) ? 1 : 0;
      checks++; if ((r.k_ack > 0) !== 1'b1) begin errors++; $display("FAIL tie_ack_seen_%0d got %0d exp ack", n, r.k_ack); end
      checks++; if (got !== exp_who) begin errors++; $display("FAIL tie_order_%0d got %0d exp %0d (0=I 1=D)", n, got, exp_who); end
      checks++; if (r.data !== exp_d) begin errors++; $display("FAIL tie_data_%0d got %h exp %h", n, r.data, exp_d); end
      if (got == 1) dreq = 1'b0; else ireq = 1'b0;
      exp_d = $urandom; slv_data = exp_d; slv_wait = $urandom_range(0, 3);
      repeat (2) @(negedge clk);
      if (n < 2) begin
        if (got == 1) begin dreq = 1'b1; daddr = $urandom; end
        else begin ireq = 1'b1; iaddr = $urandom; end
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bus_err();
    rd_t r;
    int wt;
    logic [W-1:0] d;
    wt = $urandom_range(0, 3); d = $urandom | 32'h8000_0001;
    slv_mode = M_ERR; slv_wait = wt; slv_data = d;
    daddr = $urandom; dreq = 1'b1;
    run_read(20, r);
    checks++; if ({r.acks_i, r.acks_d} !== {32'd0, 32'd1}) begin errors++; $display("FAIL err_ack_target got i=%0d d=%0d exp i=0 d=1", r.acks_i, r.acks_d); end
    checks++; if (r.k_ack !== model_ack_cycle(wt)) begin errors++; $display("FAIL err_ack_cycle got %0d exp %0d", r.k_ack, model_ack_cycle(wt)); end
    checks++; if (r.data !== 32'h0) begin errors++; $display("FAIL err_data got %h exp 0", r.data); end
    checks++; if (r.berr_n !== 1) begin errors++; $display("FAIL err_pulse got %0d exp 1", r.berr_n); end
    dreq = 1'b0;
    @(negedge clk);
    checks++; if ({bus_err_o, busy_o, dack} !== 3'b0) begin errors++; $display("FAIL err_after got %b exp 000", {bus_err_o, busy_o, dack}); end
    // ack and err together count as a normal ack.
    slv_mode = M_BOTH; slv_wait = 1; slv_data = d;
    iaddr = $urandom; ireq = 1'b1;
    run_read(20, r);
    checks++; if (r.data !== d) begin errors++; $display("FAIL both_data got %h exp %h", r.data, d); end
    checks++; if ({r.berr_n, r.acks_i} !== {32'd0, 32'd1}) begin errors++; $display("FAIL both_flags got berr=%0d i=%0d exp berr=0 i=1", r.berr_n, r.acks_i); end
    ireq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    rd_t r;
    slv_mode = M_NONE; slv_wait = 0; slv_data = 32'hFFFF_FFFF;
    iaddr = $urandom; ireq = 1'b1;
    run_read(400, r);
    checks++; if (r.stb_n !== (2 ** TW)) begin errors++; $display("FAIL timeout_stb_cycles got %0d exp %0d", r.stb_n, 2 ** TW); end
    checks++; if (r.k_ack !== (2 ** TW) + 1) begin errors++; $display("FAIL timeout_ack_cycle got %0d exp %0d", r.k_ack, (2 ** TW) + 1); end
    checks++; if (r.data !== 32'h0) begin errors++; $display("FAIL timeout_data got %h exp 0", r.data); end
    checks++; if ({r.berr_n, r.acks_i} !== {32'd1, 32'd1}) begin errors++; $display("FAIL timeout_flags got berr=%0d i=%0d exp berr=1 i=1", r.berr_n, r.acks_i); end
    ireq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    rd_t r;
    int acks, errs;
    logic stb_mid;
    logic [W-1:0] d;
    acks = 0; errs = 0; stb_mid = 1'b0; d = $urandom;
    slv_mode = M_ACK; slv_wait = 5; slv_data = d;
    iaddr = $urandom; ireq = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin stb_mid = wbm_stb_o; ireq = 1'b0; end
      if (iack || dack) acks++;
      if (bus_err_o) errs++;
    end
    checks++; if (stb_mid !== 1'b1) begin errors++; $display("FAIL withdraw_inflight got %b exp 1", stb_mid); end
    checks++; if ({acks, errs} !== {32'd0, 32'd0}) begin errors++; $display("FAIL withdraw_no_ack got acks=%0d berr=%0d exp 0 0", acks, errs); end
    checks++; if ({wbm_stb_o, busy_o} !== 2'b0) begin errors++; $display("FAIL withdraw_idle got %b exp 00", {wbm_stb_o, busy_o}); end
    slv_wait = 1; d = $urandom; slv_data = d;
    daddr = $urandom; dreq = 1'b1;
    run_read(20, r);
    checks++; if ({r.k_stb, r.k_ack, r.acks_d} !== {32'd1, 32'd3, 32'd1}) begin errors++; $display("FAIL withdraw_next got stb=%0d ack=%0d d=%0d exp 1 3 1", r.k_stb, r.k_ack, r.acks_d); end
    checks++; if (r.data !== d) begin errors++; $display("FAIL withdraw_next_data got %h exp %h", r.data, d); end
    dreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    rd_t r;
    logic [W-1:0] a, d;
    a = $urandom; d = $urandom;
    slv_mode = M_NONE; slv_wait = 0;
    iaddr = a; ireq = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wbm_stb_o !== 1'b1) begin errors++; $display("FAIL rstbus_inflight got %b exp 1", wbm_stb_o); end
    rst = 1'b0;
    #1;
    checks++; if ({wbm_cyc_o, wbm_stb_o, iack, dack, busy_o} !== 5'b0) begin errors++; $display("FAIL rstbus_async got %b exp 00000", {wbm_cyc_o, wbm_stb_o, iack, dack, busy_o}); end
    @(negedge clk);
    slv_mode = M_ACK; slv_wait = 1; slv_data = d;
    rst = 1'b1;
    run_read(20, r);
    checks++; if ({r.k_stb, r.k_ack, r.acks_i, r.acks_d} !== {32'd1, 32'd3, 32'd1, 32'd0}) begin errors++; $display("FAIL rstbus_next got stb=%0d ack=%0d i=%0d d=%0d exp 1 3 1 0", r.k_stb, r.k_ack, r.acks_i, r.acks_d); end
    checks++; if ({r.adr, r.data} !== {a & 32'hFFFF_FFFC, d}) begin errors++; $display("FAIL rstbus_next_data got %h %h exp %h %h", r.adr, r.data, a & 32'hFFFF_FFFC, d); end
    ireq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    rd_t r;
    logic who;
    int mode, wt;
    logic [W-1:0] a, d;
    for (int n = 0; n < 16; n++) begin
      who = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0: mode = M_ACK;
        1: mode = M_ERR;
        default: mode = M_BOTH;
      endcase
      wt = $urandom_range(0, 4); a = $urandom; d = $urandom | 32'h0000_0100;
      slv_mode = mode; slv_wait = wt; slv_data = d;
      if (who) begin daddr = a; dreq = 1'b1; end
      else begin iaddr = a; ireq = 1'b1; end
      run_read(30, r);
      checks++; if ({r.k_stb, r.adr} !== {32'd1, a & 32'hFFFF_FFFC}) begin errors++; $display("FAIL rnd%0d_stb got %0d %h exp 1 %h", n, r.k_stb, r.adr, a & 32'hFFFF_FFFC); end
      checks++; if (r.k_ack !== model_ack_cycle(wt)) begin errors++; $display("FAIL rnd%0d_ack_cycle got %0d exp %0d", n, r.k_ack, model_ack_cycle(wt)); end
      checks++; if ({r.acks_i, r.acks_d} !== {who ? 32'd0 : 32'd1, who ? 32'd1 : 32'd0}) begin errors++; $display("FAIL rnd%0d_target got i=%0d d=%0d exp who=%0d", n, r.acks_i, r.acks_d, who); end
      checks++; if (r.data !== model_word(mode, d)) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", n, r.data, model_word(mode, d)); end
      checks++; if (r.berr_n !== ((mode == M_ERR) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_berr got %0d exp %0d", n, r.berr_n, (mode == M_ERR) ? 1 : 0); end
      ireq = 1'b0; dreq = 1'b0;
      @(negedge clk);
      checks++; if ({iack, dack} !== 2'b0) begin errors++; $display("FAIL rnd%0d_ack_single got %b exp 00", n, {iack, dack}); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_walk();
    test_tie();
    test_bus_err();
    test_timeout();
    test_withdraw();
    test_reset_mid_bus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
